// File: rtl/sec_tick_ctrl.sv
// Seconds time base: divides clk_in_50M down to a one-cycle tick_sec enable with
// selectable acceleration, pause/single-step, and a wrapping tick counter.
module sec_tick_ctrl #(
    parameter int CLK_HZ = 50_000_000,
    parameter int CNT_W  = 26
) (
    input  logic        clk_in_50M,
    input  logic        rst_n,
    input  logic [2:0]  mode_sel,
    input  logic        mode_req,
    input  logic        run_en,
    input  logic        step_req,
    output logic        tick_sec,
    output logic [2:0]  cur_mode,
    output logic        mode_busy,
    output logic [15:0] sec_count
);

    // A divisor that rounds down to zero for a slow clock is treated as 1.
    localparam int DIV0 = (CLK_HZ > 0) ? CLK_HZ : 1;
    localparam int DIV1 = (CLK_HZ / 100 > 0) ? CLK_HZ / 100 : 1;
    localparam int DIV2 = (CLK_HZ / 500 > 0) ? CLK_HZ / 500 : 1;
    localparam int DIV3 = (CLK_HZ / 50000 > 0) ? CLK_HZ / 50000 : 1;

    localparam logic [CNT_W-1:0] LIM0 = CNT_W'(DIV0 - 1);
    localparam logic [CNT_W-1:0] LIM1 = CNT_W'(DIV1 - 1);
    localparam logic [CNT_W-1:0] LIM2 = CNT_W'(DIV2 - 1);
    localparam logic [CNT_W-1:0] LIM3 = CNT_W'(DIV3 - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PAUSE = 2'd1,
        ST_STEP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tick_q, tick_d;
    logic [15:0]       count_q, count_d;
    logic [2:0]        cur_mode_q, cur_mode_d;
    logic [2:0]        pend_mode_q, pend_mode_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  lim;
    logic              boundary;

    always_comb begin
        case (cur_mode_q)
            3'd0:    lim = LIM0;
            3'd1:    lim = LIM1;
            3'd2:    lim = LIM2;
            3'd3:    lim = LIM3;
            3'd4:    lim = '0;
            default: lim = LIM0;
        endcase
    end

    always_ff @(posedge clk_in_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (!run_en) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (run_en)        state_d = ST_RUN;
                else if (step_req) state_d = ST_STEP;
            end
            ST_STEP: state_d = ST_PAUSE;
            default: state_d = ST_RUN;
        endcase
    end

    // Tick/prescaler datapath; a pending mode lands on any boundary edge, which is
    // a tick edge in RUN/STEP or every edge while paused.
    always_comb begin
        tick_d      = 1'b0;
        cnt_d       = cnt_q;
        count_d     = count_q;
        cur_mode_d  = cur_mode_q;
        pend_mode_d = pend_mode_q;
        busy_d      = busy_q;
        boundary    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (run_en) begin
                    if (cnt_q == lim) begin
                        tick_d   = 1'b1;
                        cnt_d    = '0;
                        count_d  = count_q + 16'd1;
                        boundary = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_PAUSE: boundary = 1'b1;
            ST_STEP: begin
                tick_d   = 1'b1;
                cnt_d    = '0;
                count_d  = count_q + 16'd1;
                boundary = 1'b1;
            end
            default: ;
        endcase
        if (boundary && busy_q) begin
            cur_mode_d = pend_mode_q;
            cnt_d      = '0;
            busy_d     = 1'b0;
        end
        // A request on an applying edge only latches; it waits for the next boundary.
        if (mode_req && (mode_sel <= 3'd4)) begin
            pend_mode_d = mode_sel;
            busy_d      = 1'b1;
        end
    end

    always_ff @(posedge clk_in_50M or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            tick_q      <= 1'b0;
            count_q     <= 16'd0;
            cur_mode_q  <= 3'd0;
            pend_mode_q <= 3'd0;
            busy_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            tick_q      <= tick_d;
            count_q     <= count_d;
            cur_mode_q  <= cur_mode_d;
            pend_mode_q <= pend_mode_d;
            busy_q      <= busy_d;
        end
    end

    assign tick_sec  = tick_q;
    assign cur_mode  = cur_mode_q;
    assign mode_busy = busy_q;
    assign sec_count = count_q;

endmodule
